// File: rtl/core_task_loader_if.sv
// Dispatcher/core-side bus of one core_task_loader: task and byte handshakes,
// status pulses, and the core control word fields.
interface core_task_loader_if #(
  parameter int CNT_W = 16
);
  logic             taskValid;
  logic [6:0]       taskLen;
  logic             taskReady;
  logic             byteValid;
  logic [7:0]       byteData;
  logic             byteReady;
  logic             abort;
  logic             cProg;
  logic             cPause;
  logic [5:0]       cAddr;
  logic [7:0]       cWrData;
  logic             cStat;
  logic             taskDone;
  logic             taskErr;
  logic [CNT_W-1:0] taskCycles;

  modport slave (
    input  taskValid, taskLen, byteValid, byteData, abort, cStat,
    output taskReady, byteReady, cProg, cPause, cAddr, cWrData,
           taskDone, taskErr, taskCycles
  );

  modport master (
    output taskValid, taskLen, byteValid, byteData, abort, cStat,
    input  taskReady, byteReady, cProg, cPause, cAddr, cWrData,
           taskDone, taskErr, taskCycles
  );
endinterface

// File: rtl/core_task_loader.sv
// Per-core task sequencer: writes a task's bytes into core RAM through program
// mode, settles, releases the core, and reports completion, timeout or abort.
module core_task_loader #(
  parameter int RUN_TIMEOUT = 4096,
  parameter int CNT_W       = 16
) (
  input logic               medClk,
  input logic               rstN,
  core_task_loader_if.slave bus
);
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(RUN_TIMEOUT);

  state_t           state_r, state_s;
  logic [5:0]       last_r, last_s;
  logic [5:0]       cnt_r, cnt_s;
  logic             settle_r, settle_s;
  logic [CNT_W-1:0] run_cnt_r, run_cnt_s, run_inc_s;
  logic             fin_err_r, fin_err_s;
  logic             prog_r, prog_s;
  logic             pause_r, pause_s;
  logic [5:0]       addr_r, addr_s;
  logic [7:0]       wdata_r, wdata_s;
  logic             done_r, done_s;
  logic             err_r, err_s;
  logic [CNT_W-1:0] cycles_r, cycles_s;
  logic             task_ready_r, task_ready_s;
  logic             byte_ready_r, byte_ready_s;
  logic             len_ok_s;

  assign len_ok_s = (bus.taskLen != 7'd0) && (bus.taskLen <= 7'd64);

  // Next state and next registered outputs; bus outputs lag the state by one edge
  always_comb begin
    state_s   = state_r;
    last_s    = last_r;
    cnt_s     = cnt_r;
    settle_s  = settle_r;
    run_cnt_s = run_cnt_r;
    fin_err_s = fin_err_r;
    prog_s    = 1'b0;
    pause_s   = 1'b1;
    addr_s    = addr_r;
    wdata_s   = wdata_r;
    done_s    = 1'b0;
    err_s     = 1'b0;
    cycles_s  = cycles_r;
    run_inc_s = (run_cnt_r == CNT_MAX) ? run_cnt_r : (run_cnt_r + CNT_ONE);

    if (bus.abort && (state_r != ST_IDLE)) begin
      state_s = ST_IDLE;
      addr_s  = 6'd0;
      wdata_s = 8'd0;
      err_s   = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          addr_s  = 6'd0;
          wdata_s = 8'd0;
          if (bus.taskValid && task_ready_r) begin
            if (len_ok_s) begin
              state_s = ST_LOAD;
              last_s  = bus.taskLen[5:0] - 6'd1;
              cnt_s   = 6'd0;
            end else begin
              err_s = 1'b1;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_LOAD: begin
          // An idle LOAD cycle keeps the core paused without writing
          if (bus.byteValid && byte_ready_r) begin
            prog_s  = 1'b1;
            pause_s = 1'b0;
            addr_s  = cnt_r;
            wdata_s = bus.byteData;
            cnt_s   = cnt_r + 6'd1;
            if (cnt_r == last_r) begin
              state_s  = ST_SETTLE;
              settle_s = 1'b0;
            end else begin
              state_s = ST_LOAD;
            end
          end else begin
            prog_s  = 1'b0;
            pause_s = 1'b1;
          end
        end
        ST_SETTLE: begin
          addr_s  = 6'd0;
          wdata_s = 8'd0;
          if (settle_r) begin
            state_s   = ST_RUN;
            settle_s  = 1'b0;
            run_cnt_s = CNT_ZERO;
          end else begin
            settle_s = 1'b1;
          end
        end
        ST_RUN: begin
          pause_s   = 1'b0;
          addr_s    = 6'd0;
          wdata_s   = 8'd0;
          run_cnt_s = run_inc_s;
          // cStat is stale during the first RUN cycle; completion beats timeout
          if (bus.cStat && (run_cnt_r != CNT_ZERO)) begin
            state_s   = ST_FINISH;
            fin_err_s = 1'b0;
          end else if (run_inc_s >= CNT_TIMEOUT) begin
            state_s   = ST_FINISH;
            fin_err_s = 1'b1;
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_FINISH: begin
          addr_s   = 6'd0;
          wdata_s  = 8'd0;
          cycles_s = run_cnt_r;
          done_s   = ~fin_err_r;
          err_s    = fin_err_r;
          state_s  = ST_IDLE;
        end
        default: begin
          state_s = ST_IDLE;
          addr_s  = 6'd0;
          wdata_s = 8'd0;
        end
      endcase
    end

    task_ready_s = (state_s == ST_IDLE);
    byte_ready_s = (state_s == ST_LOAD);
  end

  // State, counters and registered bus outputs
  always_ff @(posedge medClk) begin
    if (!rstN) begin
      state_r      <= ST_IDLE;
      last_r       <= 6'd0;
      cnt_r        <= 6'd0;
      settle_r     <= 1'b0;
      run_cnt_r    <= CNT_ZERO;
      fin_err_r    <= 1'b0;
      prog_r       <= 1'b0;
      pause_r      <= 1'b1;
      addr_r       <= 6'd0;
      wdata_r      <= 8'd0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      cycles_r     <= CNT_ZERO;
      task_ready_r <= 1'b1;
      byte_ready_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      last_r       <= last_s;
      cnt_r        <= cnt_s;
      settle_r     <= settle_s;
      run_cnt_r    <= run_cnt_s;
      fin_err_r    <= fin_err_s;
      prog_r       <= prog_s;
      pause_r      <= pause_s;
      addr_r       <= addr_s;
      wdata_r      <= wdata_s;
      done_r       <= done_s;
      err_r        <= err_s;
      cycles_r     <= cycles_s;
      task_ready_r <= task_ready_s;
      byte_ready_r <= byte_ready_s;
    end
  end

  assign bus.taskReady  = task_ready_r;
  assign bus.byteReady  = byte_ready_r;
  assign bus.cProg      = prog_r;
  assign bus.cPause     = pause_r;
  assign bus.cAddr      = addr_r;
  assign bus.cWrData    = wdata_r;
  assign bus.taskDone   = done_r;
  assign bus.taskErr    = err_r;
  assign bus.taskCycles = cycles_r;
endmodule
